// File: rtl/vga_timing_core.sv
// Runtime-programmable VGA/DVI timing generator with a fractional pixel enable and double-buffered timing.
// Counter outputs (pixel_x/y, pixel_en) are undelayed; hs/vs/de/colour appear PIXEL_DELAY clk later.
// No backpressure: free-running; cfg_load is a one-clk strobe and is always accepted.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   ext_factor_mul/div  fractional enable ratio (pixel_en rate = mul/div, div > 0)
//   cfg_*, cfg_load     shadow timing/shift values, captured on cfg_load, applied at frame end
//   cfg_pending         shadow holds values not yet applied
//   ext_color           pixel colour, already aligned by the source to the output delay
//   ext_vga_hs/vs/de    delayed syncs and data enable; ext_vga_color gated by delayed de
//   pixel_x/y, pixel_en undelayed scaled coordinates and counter advance strobe
//   frame_start         one-clk pulse after counters wrap to (0,0)
//   vblank_start        one-clk pulse after the line wrap that enters the first blank line
module vga_timing_core #(
  parameter int LINE_BITS    = 12,
  parameter int COUNTER_BITS = 8,
  parameter int BPP          = 8,
  parameter int PIXEL_DELAY  = 7,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int DEF_H_VIS    = 640,
  parameter int DEF_H_SS     = 656,
  parameter int DEF_H_SE     = 752,
  parameter int DEF_H_TOT    = 799,
  parameter int DEF_V_VIS    = 480,
  parameter int DEF_V_SS     = 490,
  parameter int DEF_V_SE     = 492,
  parameter int DEF_V_TOT    = 524
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [COUNTER_BITS-1:0] ext_factor_mul,
  input  logic signed [COUNTER_BITS-1:0] ext_factor_div,
  input  logic        [LINE_BITS-1:0]    cfg_h_vis,
  input  logic        [LINE_BITS-1:0]    cfg_h_ss,
  input  logic        [LINE_BITS-1:0]    cfg_h_se,
  input  logic        [LINE_BITS-1:0]    cfg_h_tot,
  input  logic        [LINE_BITS-1:0]    cfg_v_vis,
  input  logic        [LINE_BITS-1:0]    cfg_v_ss,
  input  logic        [LINE_BITS-1:0]    cfg_v_se,
  input  logic        [LINE_BITS-1:0]    cfg_v_tot,
  input  logic        [2:0]              cfg_shift_h,
  input  logic        [2:0]              cfg_shift_v,
  input  logic                           cfg_load,
  output logic                           cfg_pending,
  input  logic        [BPP-1:0]          ext_color,
  output logic                           ext_vga_hs,
  output logic                           ext_vga_vs,
  output logic                           ext_vga_de,
  output logic        [BPP-1:0]          ext_vga_color,
  output logic        [LINE_BITS-1:0]    pixel_x,
  output logic        [LINE_BITS-1:0]    pixel_y,
  output logic                           pixel_en,
  output logic                           frame_start,
  output logic                           vblank_start
);

  typedef struct packed {
    logic [LINE_BITS-1:0] h_vis;
    logic [LINE_BITS-1:0] h_ss;
    logic [LINE_BITS-1:0] h_se;
    logic [LINE_BITS-1:0] h_tot;
    logic [LINE_BITS-1:0] v_vis;
    logic [LINE_BITS-1:0] v_ss;
    logic [LINE_BITS-1:0] v_se;
    logic [LINE_BITS-1:0] v_tot;
    logic [2:0]           shift_h;
    logic [2:0]           shift_v;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    h_vis: LINE_BITS'(DEF_H_VIS), h_ss: LINE_BITS'(DEF_H_SS),
    h_se:  LINE_BITS'(DEF_H_SE),  h_tot: LINE_BITS'(DEF_H_TOT),
    v_vis: LINE_BITS'(DEF_V_VIS), v_ss: LINE_BITS'(DEF_V_SS),
    v_se:  LINE_BITS'(DEF_V_SE),  v_tot: LINE_BITS'(DEF_V_TOT),
    shift_h: 3'd0, shift_v: 3'd0
  };

  // Pipe entry order is {hs level, vs level, de}; idle means both syncs inactive, de low.
  localparam logic [2:0] PIPE_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  timing_t act;
  timing_t shadow;
  timing_t cfg_in;

  assign cfg_in = '{
    h_vis: cfg_h_vis, h_ss: cfg_h_ss, h_se: cfg_h_se, h_tot: cfg_h_tot,
    v_vis: cfg_v_vis, v_ss: cfg_v_ss, v_se: cfg_v_se, v_tot: cfg_v_tot,
    shift_h: cfg_shift_h, shift_v: cfg_shift_v
  };

  // Fractional enable: one extra bit keeps acc+mul from overflowing before the compare.
  logic signed [COUNTER_BITS-1:0] acc;
  logic signed [COUNTER_BITS:0]   sum;
  logic signed [COUNTER_BITS:0]   div_ext;
  logic signed [COUNTER_BITS:0]   rem;

  assign sum     = {acc[COUNTER_BITS-1], acc} + {ext_factor_mul[COUNTER_BITS-1], ext_factor_mul};
  assign div_ext = {ext_factor_div[COUNTER_BITS-1], ext_factor_div};
  assign rem     = sum - div_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      pixel_en <= 1'b0;
    end else if (sum >= div_ext) begin
      acc      <= rem[COUNTER_BITS-1:0];
      pixel_en <= 1'b1;
    end else begin
      acc      <= sum[COUNTER_BITS-1:0];
      pixel_en <= 1'b0;
    end
  end

  logic [LINE_BITS-1:0] count_h;
  logic [LINE_BITS-1:0] count_v;
  logic [LINE_BITS-1:0] count_v_next;
  logic                 h_end;
  logic                 v_end;
  logic                 boundary;

  // >= rather than == so a counter already past a newly shrunk total still wraps.
  assign h_end        = count_h >= act.h_tot;
  assign v_end        = count_v >= act.v_tot;
  assign boundary     = pixel_en && h_end && v_end;
  assign count_v_next = v_end ? '0 : count_v + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_h      <= '0;
      count_v      <= '0;
      act          <= DEF_TIMING;
      shadow       <= DEF_TIMING;
      cfg_pending  <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      frame_start  <= boundary;
      vblank_start <= pixel_en && h_end && (count_v_next == act.v_vis);
      if (pixel_en) begin
        if (h_end) begin
          count_h <= '0;
          count_v <= count_v_next;
        end else begin
          count_h <= count_h + 1'b1;
        end
      end
      // A load in the boundary clk lands in shadow after the swap has taken the old shadow,
      // so the new values stay pending for the following frame.
      if (boundary && cfg_pending) begin
        act <= shadow;
      end
      if (cfg_load) begin
        shadow      <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (boundary) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Sync/de decode; ss >= se simply never matches, leaving the sync inactive.
  logic hs_act;
  logic vs_act;
  logic hs_lvl;
  logic vs_lvl;
  logic de_raw;

  assign hs_act = (count_h >= act.h_ss) && (count_h < act.h_se);
  assign vs_act = (count_v >= act.v_ss) && (count_v < act.v_se);
  assign hs_lvl = HS_POL ? hs_act : ~hs_act;
  assign vs_lvl = VS_POL ? vs_act : ~vs_act;
  assign de_raw = (count_h < act.h_vis) && (count_v < act.v_vis);

  // Alignment pipe runs every clk, independent of pixel_en.
  logic [PIXEL_DELAY-1:0][2:0] pipe;
  logic [PIXEL_DELAY:0][2:0]   pipe_in;

  assign pipe_in = {pipe, hs_lvl, vs_lvl, de_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= {PIXEL_DELAY{PIPE_IDLE}};
    end else begin
      pipe <= pipe_in[PIXEL_DELAY-1:0];
    end
  end

  assign {ext_vga_hs, ext_vga_vs, ext_vga_de} = pipe[PIXEL_DELAY-1];
  assign ext_vga_color = ext_vga_de ? ext_color : '0;

  assign pixel_x = count_h >> act.shift_h;
  assign pixel_y = count_v >> act.shift_v;

endmodule

// File: tb/tb_vga_timing_core.sv
module tb_vga_timing_core;

  localparam int LB  = 12;
  localparam int CB  = 8;
  localparam int BPP = 8;
  localparam int PD  = 7;
  // Short default frame (8 lines) so full frames fit in a short run; H timing is standard 640x480.
  localparam int DHV = 640, DHS = 656, DHE = 752, DHT = 799;
  localparam int DVV = 4,   DVS = 5,   DVE = 6,   DVT = 7;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic signed [CB-1:0]  mul = 8'sd1;
  logic signed [CB-1:0]  div = 8'sd1;
  logic [LB-1:0]         cfg_h_vis, cfg_h_ss, cfg_h_se, cfg_h_tot;
  logic [LB-1:0]         cfg_v_vis, cfg_v_ss, cfg_v_se, cfg_v_tot;
  logic [2:0]            cfg_shift_h, cfg_shift_v;
  logic                  cfg_load = 1'b0;
  logic                  cfg_pending;
  logic [BPP-1:0]        ext_color = '0;
  logic                  ext_vga_hs, ext_vga_vs, ext_vga_de;
  logic [BPP-1:0]        ext_vga_color;
  logic [LB-1:0]         pixel_x, pixel_y;
  logic                  pixel_en, frame_start, vblank_start;

  always #5 clk = ~clk;

  vga_timing_core #(
    .LINE_BITS(LB), .COUNTER_BITS(CB), .BPP(BPP), .PIXEL_DELAY(PD),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .DEF_H_VIS(DHV), .DEF_H_SS(DHS), .DEF_H_SE(DHE), .DEF_H_TOT(DHT),
    .DEF_V_VIS(DVV), .DEF_V_SS(DVS), .DEF_V_SE(DVE), .DEF_V_TOT(DVT)
  ) dut (
    .clk(clk), .reset(reset),
    .ext_factor_mul(mul), .ext_factor_div(div),
    .cfg_h_vis(cfg_h_vis), .cfg_h_ss(cfg_h_ss), .cfg_h_se(cfg_h_se), .cfg_h_tot(cfg_h_tot),
    .cfg_v_vis(cfg_v_vis), .cfg_v_ss(cfg_v_ss), .cfg_v_se(cfg_v_se), .cfg_v_tot(cfg_v_tot),
    .cfg_shift_h(cfg_shift_h), .cfg_shift_v(cfg_shift_v),
    .cfg_load(cfg_load), .cfg_pending(cfg_pending),
    .ext_color(ext_color),
    .ext_vga_hs(ext_vga_hs), .ext_vga_vs(ext_vga_vs), .ext_vga_de(ext_vga_de),
    .ext_vga_color(ext_vga_color),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_en(pixel_en), .frame_start(frame_start), .vblank_start(vblank_start)
  );

  typedef struct {
    int h_vis, h_ss, h_se, h_tot, v_vis, v_ss, v_se, v_tot, sh, sv;
  } tim_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } pix_t;

  typedef struct {
    int mul, div, n, exp_cnt;
  } frac_vec_t;

  // Reference model state.
  tim_t  m_act, m_sh, cur_cfg;
  int    m_acc, m_h, m_v;
  bit    m_pen, m_pend, m_fs, m_vb;
  pix_t  exp_q[$];

  // Measurements taken from DUT outputs.
  int    fall_q[$], low_q[$], fs_q[$], vb_q[$], de_at_fall[$];
  int    cyc, de_cnt, last_fall, first_de;
  bit    prev_hs, have_fall;

  int    checks = 0;
  int    errors = 0;

  function automatic tim_t mk_tim(int a, int b, int c, int d, int e, int f, int g, int h, int s1, int s2);
    tim_t t;
    t.h_vis = a; t.h_ss = b; t.h_se = c; t.h_tot = d;
    t.v_vis = e; t.v_ss = f; t.v_se = g; t.v_tot = h;
    t.sh = s1; t.sv = s2;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic set_cfg(input tim_t t);
    cur_cfg     = t;
    cfg_h_vis   = LB'(t.h_vis); cfg_h_ss = LB'(t.h_ss); cfg_h_se = LB'(t.h_se); cfg_h_tot = LB'(t.h_tot);
    cfg_v_vis   = LB'(t.v_vis); cfg_v_ss = LB'(t.v_ss); cfg_v_se = LB'(t.v_se); cfg_v_tot = LB'(t.v_tot);
    cfg_shift_h = 3'(t.sh);     cfg_shift_v = 3'(t.sv);
  endtask

  task automatic clear_meas();
    fall_q.delete(); low_q.delete(); fs_q.delete(); vb_q.delete(); de_at_fall.delete();
    prev_hs   = ext_vga_hs;
    have_fall = 1'b0;
    first_de  = -1;
  endtask

  task automatic model_reset();
    pix_t idle;
    m_act = mk_tim(DHV, DHS, DHE, DHT, DVV, DVS, DVE, DVT, 0, 0);
    m_sh  = m_act;
    m_acc = 0; m_h = 0; m_v = 0;
    m_pen = 0; m_pend = 0; m_fs = 0; m_vb = 0;
    idle.hs = 1'b1; idle.vs = 1'b1; idle.de = 1'b0;
    exp_q.delete();
    for (int i = 0; i < PD - 1; i++) exp_q.push_back(idle);
  endtask

  function automatic pix_t model_raw();
    pix_t p;
    p.hs = !(m_h >= m_act.h_ss && m_h < m_act.h_se);
    p.vs = !(m_v >= m_act.v_ss && m_v < m_act.v_se);
    p.de = (m_h < m_act.h_vis) && (m_v < m_act.v_vis);
    return p;
  endfunction

  task automatic model_step();
    int sum, nacc;
    bit npen, nfs, nvb, bnd;
    sum = m_acc + int'(mul);
    if (sum >= int'(div)) begin nacc = sum - int'(div); npen = 1'b1; end
    else begin nacc = sum; npen = 1'b0; end
    bnd = m_pen && m_h >= m_act.h_tot && m_v >= m_act.v_tot;
    nfs = bnd;
    nvb = 1'b0;
    if (m_pen) begin
      if (m_h >= m_act.h_tot) begin
        m_h = 0;
        m_v = (m_v >= m_act.v_tot) ? 0 : m_v + 1;
        nvb = (m_v == m_act.v_vis);
      end else begin
        m_h = m_h + 1;
      end
    end
    if (bnd && m_pend) begin m_act = m_sh; m_pend = 1'b0; end
    if (cfg_load) begin m_sh = cur_cfg; m_pend = 1'b1; end
    m_acc = nacc; m_pen = npen; m_fs = nfs; m_vb = nvb;
  endtask

  // One clk: push the expected pipe entry, clock, then compare every output at the negedge.
  task automatic tick();
    pix_t e;
    ext_color = BPP'($urandom);
    exp_q.push_back(model_raw());
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    check("hs",           ext_vga_hs,    e.hs);
    check("vs",           ext_vga_vs,    e.vs);
    check("de",           ext_vga_de,    e.de);
    check("color",        ext_vga_color, e.de ? int'(ext_color) : 0);
    check("pixel_en",     pixel_en,      m_pen);
    check("pixel_x",      pixel_x,       m_h >> m_act.sh);
    check("pixel_y",      pixel_y,       m_v >> m_act.sv);
    check("cfg_pending",  cfg_pending,   m_pend);
    check("frame_start",  frame_start,   m_fs);
    check("vblank_start", vblank_start,  m_vb);
    if (prev_hs && !ext_vga_hs) begin
      fall_q.push_back(cyc); de_at_fall.push_back(de_cnt);
      last_fall = cyc; have_fall = 1'b1;
    end
    if (!prev_hs && ext_vga_hs && have_fall) low_q.push_back(cyc - last_fall);
    prev_hs = ext_vga_hs;
    if (ext_vga_de) begin
      de_cnt++;
      if (first_de < 0) first_de = cyc;
    end
    if (frame_start)  fs_q.push_back(cyc);
    if (vblank_start) vb_q.push_back(cyc);
  endtask

  task automatic do_reset(input bit check_idle);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (check_idle) begin
      check("rst_hs", ext_vga_hs, 1);   check("rst_vs", ext_vga_vs, 1);
      check("rst_de", ext_vga_de, 0);   check("rst_pen", pixel_en, 0);
      check("rst_px", pixel_x, 0);      check("rst_py", pixel_y, 0);
      check("rst_pend", cfg_pending, 0); check("rst_fs", frame_start, 0);
      check("rst_vb", vblank_start, 0);
    end
    model_reset();
    cyc = 0; de_cnt = 0;
    clear_meas();
    prev_hs = 1'b1;
    reset = 1'b1;
  endtask

  task automatic wait_fs(input int target, input int budget, input string name);
    for (int i = 0; i < budget && fs_q.size() < target; i++) tick();
    check(name, fs_q.size() >= target, 1);
  endtask

  task automatic wait_fall(input int target, input int budget, input string name);
    for (int i = 0; i < budget && fall_q.size() < target; i++) tick();
    check(name, fall_q.size() >= target, 1);
  endtask

  task automatic run_to_pos(input int h, input int v, input int budget, input string name);
    for (int i = 0; i < budget && !(m_h == h && m_v == v); i++) tick();
    check(name, (m_h == h && m_v == v), 1);
  endtask

  frac_vec_t ftab[6];
  tim_t tdef, tx, ta, tb, tc, td;
  int cnt;

  initial begin
    ftab[0] = '{1, 1, 40, 40};
    ftab[1] = '{1, 4, 40, 10};
    ftab[2] = '{0, 5, 40, 0};
    ftab[3] = '{3, 4, 40, 30};
    ftab[4] = '{2, 5, 40, 16};
    ftab[5] = '{5, 7, 42, 30};
    tdef = mk_tim(DHV, DHS, DHE, DHT, DVV, DVS, DVE, DVT, 0, 0);
    tx   = mk_tim(10, 12, 14, 20, 3, 4, 5, 9, 0, 0);
    ta   = mk_tim(80, 84, 92, 99, 6, 7, 8, 9, 0, 0);
    tb   = mk_tim(40, 44, 50, 59, 6, 7, 8, 9, 0, 0);
    tc   = mk_tim(30, 32, 36, 39, 6, 7, 8, 9, 0, 0);
    td   = mk_tim(DHV, DHS, DHE, DHT, DVV, DVS, DVE, DVT, 2, 1);
    set_cfg(tdef);

    // Fractional enable ratios from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      mul = CB'(ftab[i].mul);
      div = CB'(ftab[i].div);
      do_reset(i == 0);
      cnt = 0;
      for (int k = 0; k < ftab[i].n; k++) begin
        tick();
        cnt += int'(pixel_en);
      end
      check("frac_cnt", cnt, ftab[i].exp_cnt);
    end

    // Default timing at full rate.
    mul = 8'sd1; div = 8'sd1;
    do_reset(1'b0);
    wait_fs(2, 14000, "frame_timeout");
    check("first_de", first_de, PD);
    check("first_hs_fall", fall_q[0], 664);
    check("hs_period", fall_q[1] - fall_q[0], 800);
    check("hs_low", low_q[0], 96);
    check("de_per_line", de_at_fall[1] - de_at_fall[0], 640);
    check("first_frame", fs_q[0], 6401);
    if (fs_q.size() >= 2) begin
      check("frame_period", fs_q[1] - fs_q[0], 6400);
      cnt = 0;
      foreach (vb_q[i]) if (vb_q[i] > fs_q[0] && vb_q[i] < fs_q[1]) cnt++;
      check("vblank_per_frame", cnt, 1);
    end

    // Quarter-rate enable stretches every count by 4.
    mul = 8'sd1; div = 8'sd4;
    do_reset(1'b0);
    wait_fall(2, 8000, "div4_timeout");
    check("hs_period_div4", fall_q[1] - fall_q[0], 3200);
    check("hs_low_div4", low_q[0], 384);

    // Mid-frame load (overwritten once) waits for the frame boundary.
    mul = 8'sd1; div = 8'sd1;
    do_reset(1'b0);
    repeat (3000) tick();
    set_cfg(tx); cfg_load = 1'b1; tick();
    set_cfg(ta); tick();
    cfg_load = 1'b0;
    check("pending_set", cfg_pending, 1);
    clear_meas();
    wait_fs(1, 5000, "swap_timeout");
    check("old_hs_period", fall_q[1] - fall_q[0], 800);
    check("old_hs_low", low_q[0], 96);
    check("pending_clr", cfg_pending, 0);
    wait_fs(3, 2500, "new_frame_timeout");
    check("new_frame_a", fs_q[1] - fs_q[0], 1000);
    check("new_frame_b", fs_q[2] - fs_q[1], 1000);

    // Load in the boundary clk: pending B activates, C stays pending one more frame.
    set_cfg(tb); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    run_to_pos(99, 9, 1200, "reach_boundary");
    set_cfg(tc); cfg_load = 1'b1;
    clear_meas();
    tick();
    cfg_load = 1'b0;
    check("pending_after_bnd_load", cfg_pending, 1);
    wait_fs(3, 1500, "bnd_load_timeout");
    check("frame_b", fs_q[1] - fs_q[0], 600);
    check("frame_c", fs_q[2] - fs_q[1], 400);
    check("pending_c_clr", cfg_pending, 0);

    // Pixel scaling.
    set_cfg(td); cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    clear_meas();
    wait_fs(1, 1000, "shift_timeout");
    run_to_pos(3, 0, 50, "pos_3_0");     check("px_3", pixel_x, 0);
    run_to_pos(4, 0, 50, "pos_4_0");     check("px_4", pixel_x, 1);
    run_to_pos(639, 0, 900, "pos_639");  check("px_639", pixel_x, 159);
    run_to_pos(799, 0, 900, "pos_799");  check("px_799", pixel_x, 199);
    run_to_pos(0, 1, 900, "pos_0_1");    check("py_1", pixel_y, 0);
    run_to_pos(0, 2, 900, "pos_0_2");    check("py_2", pixel_y, 1);
    run_to_pos(0, 3, 900, "pos_0_3");    check("py_3", pixel_y, 1);

    // Reset mid-line: outputs go idle without waiting for a clock.
    run_to_pos(300, 3, 900, "pos_300");
    reset = 1'b0;
    #1;
    check("mid_rst_hs", ext_vga_hs, 1);
    check("mid_rst_vs", ext_vga_vs, 1);
    check("mid_rst_de", ext_vga_de, 0);
    check("mid_rst_color", ext_vga_color, 0);
    check("mid_rst_pen", pixel_en, 0);
    check("mid_rst_px", pixel_x, 0);
    do_reset(1'b0);
    run_to_pos(5, 0, 20, "resume_pos");
    check("resume_px", pixel_x, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
